// File: rtl/riscv_fetch_pkg.sv
// Types and constants shared by the fetch stage and its neighbours.
package riscv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN,
        HALT
    } fetch_state_t;

    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one imem read in flight, and feeds decode through a one-entry output register.
// Ack in cycle n gives out_valid in n+1; if out_ready is low at ack time the stage parks in HOLD with imem_req low.
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic            fetch_misaligned
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] drain_addr, drain_addr_nxt;
    logic            halt_pending, halt_pending_nxt;
    logic            out_valid_nxt;
    logic [XLEN-1:0] out_instruction_nxt, out_pc_nxt;
    logic            misaligned_nxt;

    logic redir, redir_ok, redir_bad, fetch_ack;

    assign redir     = redirect_valid && (state != HALT);
    assign redir_ok  = redir && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redir && (redirect_pc[1:0] != 2'b00);
    assign fetch_ack = (state == FETCH) && imem_ack;

    // While draining, the bus must keep showing the address that was actually requested.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        state_nxt           = state;
        pc_nxt              = pc;
        drain_addr_nxt      = drain_addr;
        halt_pending_nxt    = halt_pending;
        out_valid_nxt       = out_valid;
        out_instruction_nxt = out_instruction;
        out_pc_nxt          = out_pc;
        misaligned_nxt      = fetch_misaligned;

        if (redir) begin
            out_valid_nxt = 1'b0;
        end else if (fetch_ack) begin
            out_valid_nxt       = 1'b1;
            out_instruction_nxt = imem_rdata;
            out_pc_nxt          = pc;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (redir_ok) begin
            pc_nxt = redirect_pc;
        end else if (fetch_ack && !redir) begin
            pc_nxt = pc_incr(pc);
        end

        if (redir_bad) begin
            misaligned_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                state_nxt = redir_bad ? HALT : FETCH;
            end
            FETCH: begin
                if (redir) begin
                    if (imem_ack) begin
                        state_nxt = redir_bad ? HALT : FETCH;
                    end else begin
                        state_nxt        = DRAIN;
                        drain_addr_nxt   = pc;
                        halt_pending_nxt = redir_bad;
                    end
                end else if (imem_ack) begin
                    // Decode's ready at ack time predicts whether the new word drains next cycle.
                    state_nxt = out_ready ? FETCH : HOLD;
                end
            end
            HOLD: begin
                if (redir_bad) begin
                    state_nxt = HALT;
                end else if (redir_ok || out_ready) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (redir_bad) begin
                    halt_pending_nxt = 1'b1;
                end
                if (imem_ack) begin
                    state_nxt = (halt_pending || redir_bad) ? HALT : FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            drain_addr       <= RESET_PC;
            halt_pending     <= 1'b0;
            out_valid        <= 1'b0;
            out_instruction  <= '0;
            out_pc           <= '0;
            fetch_misaligned <= 1'b0;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            drain_addr       <= drain_addr_nxt;
            halt_pending     <= halt_pending_nxt;
            out_valid        <= out_valid_nxt;
            out_instruction  <= out_instruction_nxt;
            out_pc           <= out_pc_nxt;
            fetch_misaligned <= misaligned_nxt;
        end
    end

endmodule
